// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR decimator controller driving one external 16s x 15u multiplier.
// Define FIR_MAC_SEQUENCER_ROUND_EN to round half toward +inf before the output shift.
module fir_mac_sequencer #(
    parameter  int unsigned NTAPS     = 16,
    parameter  int unsigned DECIM     = 2,
    parameter  int unsigned OUT_SHIFT = 15,
    parameter  int unsigned ACC_W     = 37,
    localparam int unsigned AW        = $clog2(NTAPS)
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic signed [15:0]  s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic signed [15:0]  m_data,
    output logic                m_valid,
    input  logic                m_ready,
    input  logic                coef_we,
    input  logic [AW-1:0]       coef_addr,
    input  logic [14:0]         coef_din,
    output logic signed [15:0]  mul_a,
    output logic [14:0]         mul_b,
    input  logic signed [30:0]  mul_p,
    output logic                busy
);

    localparam int unsigned PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);
    localparam logic [AW-1:0]   TAP_LAST = AW'(NTAPS - 1);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_LO = -(ACC_W'(32768));
`ifdef FIR_MAC_SEQUENCER_ROUND_EN
    localparam logic signed [ACC_W-1:0] RND = ACC_W'((64'(1) << OUT_SHIFT) >> 1);
`else
    localparam logic signed [ACC_W-1:0] RND = '0;
`endif

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                    state_q, state_d;
    logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]             tap_q, tap_d;
    logic [PH_W-1:0]           phase_q, phase_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [15:0]        dline [NTAPS];
    logic [14:0]               coef  [NTAPS];

    logic                      s_ready_d, busy_d, m_valid_d;
    logic signed [15:0]        m_data_d, mul_a_d;
    logic [14:0]               mul_b_d;
    logic                      in_xfer, coef_wr;
    logic [AW-1:0]             rd_addr;
    logic signed [ACC_W-1:0]   sum_c, shf_c;
    logic signed [15:0]        sat_c;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        tap_d     = tap_q;
        phase_d   = phase_q;
        acc_d     = acc_q;
        m_valid_d = m_valid;
        m_data_d  = m_data;
        mul_a_d   = '0;
        mul_b_d   = '0;
        in_xfer   = 1'b0;
        coef_wr   = 1'b0;
        rd_addr   = '0;

        sum_c = acc_q + ACC_W'(mul_p);
        shf_c = (acc_q + RND) >>> OUT_SHIFT;
        if (shf_c > SAT_HI)      sat_c = 16'sh7fff;
        else if (shf_c < SAT_LO) sat_c = 16'sh8000;
        else                     sat_c = shf_c[15:0];

        case (state_q)
            IDLE: begin
                coef_wr = coef_we;
                if (s_valid && s_ready) begin
                    in_xfer  = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    if (phase_q == PH_LAST) begin
                        phase_d = '0;
                        tap_d   = '0;
                        acc_d   = '0;
                        state_d = MAC;
                        // Tap 0 operands: the sample and coefficient being written this edge
                        mul_a_d = s_data;
                        mul_b_d = (coef_we && coef_addr == '0) ? coef_din : coef[0];
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end
            end
            MAC: begin
                acc_d = sum_c;
                tap_d = tap_q + AW'(1);
                if (tap_q == TAP_LAST) begin
                    state_d = OUT;
                end else begin
                    // Operands are registered one cycle ahead, so fetch tap_q+1
                    rd_addr = wr_ptr_q - tap_q - AW'(2);
                    mul_a_d = dline[rd_addr];
                    mul_b_d = coef[tap_q + AW'(1)];
                end
            end
            OUT: begin
                if (!m_valid) begin
                    m_valid_d = 1'b1;
                    m_data_d  = sat_c;
                end else if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        s_ready_d = (state_d == IDLE);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            tap_q    <= '0;
            phase_q  <= '0;
            acc_q    <= '0;
            s_ready  <= 1'b0;
            busy     <= 1'b0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            for (int i = 0; i < int'(NTAPS); i++) begin
                dline[i] <= '0;
                coef[i]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            tap_q    <= tap_d;
            phase_q  <= phase_d;
            acc_q    <= acc_d;
            s_ready  <= s_ready_d;
            busy     <= busy_d;
            m_valid  <= m_valid_d;
            m_data   <= m_data_d;
            mul_a    <= mul_a_d;
            mul_b    <= mul_b_d;
            if (in_xfer) dline[wr_ptr_q]  <= s_data;
            if (coef_wr) coef[coef_addr]  <= coef_din;
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: convolution/latency reference model, directed cases and random traffic.
// Honours FIR_MAC_SEQUENCER_ROUND_EN the same way as the design.
module tb_fir_mac_sequencer;

    localparam int unsigned NTAPS     = 16;
    localparam int unsigned DECIM     = 2;
    localparam int unsigned OUT_SHIFT = 15;
    localparam int unsigned ACC_W     = 37;
    localparam int unsigned AW        = $clog2(NTAPS);
`ifdef FIR_MAC_SEQUENCER_ROUND_EN
    localparam int TRUNC_EXP = -1;
    localparam int GATE_EXP  = 100;
`else
    localparam int TRUNC_EXP = -2;
    localparam int GATE_EXP  = 99;
`endif

    logic                ap_clk = 1'b0;
    logic                ap_rst = 1'b1;
    logic signed [15:0]  s_data = '0;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic signed [15:0]  m_data;
    logic                m_valid;
    logic                m_ready = 1'b1;
    logic                coef_we = 1'b0;
    logic [AW-1:0]       coef_addr = '0;
    logic [14:0]         coef_din = '0;
    logic signed [15:0]  mul_a;
    logic [14:0]         mul_b;
    logic signed [30:0]  mul_p;
    logic                busy;

    always #5 ap_clk = ~ap_clk;

    fir_mac_sequencer #(
        .NTAPS(NTAPS), .DECIM(DECIM), .OUT_SHIFT(OUT_SHIFT), .ACC_W(ACC_W)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_din(coef_din),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .busy(busy)
    );

    // The shared multiplier that lives next to the sequencer in the stage wrapper
    logic signed [31:0] prod;
    assign prod  = mul_a * $signed({1'b0, mul_b});
    assign mul_p = prod[30:0];

    int vectors = 0;
    int miscompares = 0;

    function automatic void chk(string name, longint act, longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model: sample history, coefficient table, and output timing by cycle count
    int   hist  [NTAPS];
    int   mcoef [NTAPS];
    int   wp, ph, lat, pend, exp_mdata;
    bit   exp_sready, exp_busy, exp_mvalid;
    int   got[$];
    logic signed [15:0] smp_mdata;

    function automatic int model_out();
        longint sum = 0;
        for (int k = 0; k < int'(NTAPS); k++)
            sum += longint'(hist[(wp - 1 - k + int'(NTAPS)) % int'(NTAPS)]) * longint'(mcoef[k]);
`ifdef FIR_MAC_SEQUENCER_ROUND_EN
        sum += longint'(1) << (OUT_SHIFT - 1);
`endif
        sum = sum >>> OUT_SHIFT;
        if (sum > 32767)  sum = 32767;
        if (sum < -32768) sum = -32768;
        return int'(sum);
    endfunction

    always @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            for (int i = 0; i < int'(NTAPS); i++) begin
                hist[i]  = 0;
                mcoef[i] = 0;
            end
            wp = 0; ph = 0; lat = 0; pend = 0; exp_mdata = 0;
            exp_sready = 0; exp_busy = 0; exp_mvalid = 0;
        end else begin
            bit in_x, out_x;
            in_x  = exp_sready && s_valid;
            out_x = exp_mvalid && m_ready;
            if (coef_we && !exp_busy) mcoef[coef_addr] = int'(coef_din);
            if (out_x) begin
                got.push_back(int'(smp_mdata));
                exp_mvalid = 0;
                exp_busy   = 0;
            end else if (exp_busy && !exp_mvalid) begin
                lat++;
                if (lat == int'(NTAPS) + 1) begin
                    exp_mvalid = 1;
                    exp_mdata  = pend;
                end
            end
            if (in_x) begin
                hist[wp] = int'(s_data);
                wp = (wp + 1) % int'(NTAPS);
                if (ph == int'(DECIM) - 1) begin
                    ph = 0;
                    pend = model_out();
                    exp_busy = 1;
                    lat = 0;
                end else begin
                    ph++;
                end
            end
            exp_sready = !exp_busy;
        end
    end

    // Per-cycle compare against the model, sampled mid-cycle
    always @(negedge ap_clk) begin
        smp_mdata = m_data;
        if (!ap_rst) begin
            chk("s_ready", longint'(s_ready), longint'(exp_sready));
            chk("busy", longint'(busy), longint'(exp_busy));
            chk("m_valid", longint'(m_valid), longint'(exp_mvalid));
            if (exp_mvalid) chk("m_data", longint'(m_data), longint'(exp_mdata));
            if (!exp_busy) begin
                chk("mul_a_idle", longint'(mul_a), 0);
                chk("mul_b_idle", longint'(mul_b), 0);
            end
        end
    end

    task automatic push(input logic signed [15:0] d);
        bit done = 0;
        s_data  = d;
        s_valid = 1'b1;
        for (int i = 0; i < 500 && !done; i++) begin
            bit ok = s_ready;
            @(negedge ap_clk);
            done = ok;
        end
        s_valid = 1'b0;
        chk("push_accepted", longint'(done), 1);
    endtask

    task automatic wcoef(input int a, input int v);
        coef_we   = 1'b1;
        coef_addr = AW'(a);
        coef_din  = 15'(v);
        @(negedge ap_clk);
        coef_we   = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 500 && !(s_ready && !m_valid); i++) @(negedge ap_clk);
        chk("drained", longint'(s_ready && !m_valid), 1);
    endtask

    task automatic push_n(input int n, input int d);
        for (int i = 0; i < n; i++) push(16'(d));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base, v;

        repeat (3) @(negedge ap_clk);
        chk("rst_m_valid", longint'(m_valid), 0);
        chk("rst_s_ready", longint'(s_ready), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_m_data", longint'(m_data), 0);
        chk("rst_mul_a", longint'(mul_a), 0);
        ap_rst = 1'b0;
        @(negedge ap_clk);
        chk("s_ready_after_rst", longint'(s_ready), 1);

        // Scaling, latency and truncation
        wcoef(0, 16384);
        push(16'sd1000);
        push(16'sd2000);
        n = 0;
        while (!m_valid && n < 100) begin
            @(negedge ap_clk);
            n++;
        end
        chk("latency", longint'(n), longint'(NTAPS + 1));
        drain();
        chk("scale_1000", longint'(got[$]), 1000);
        push(-16'sd3);
        push(-16'sd3);
        drain();
        chk("trunc_minus3", longint'(got[$]), longint'(TRUNC_EXP));

        // Tap ordering: coef[15] = 32768 does not fit 15 bits and reads as 0
        for (int k = 0; k < int'(NTAPS); k++) wcoef(k, 2048 * (k + 1));
        push_n(NTAPS, 0);
        drain();
        base = got.size();
        push(16'sd16384);
        push_n(19, 0);
        drain();
        chk("tap_out0", longint'(got[base]), 2048);
        chk("tap_out1", longint'(got[base + 1]), 4096);
        chk("tap_out6", longint'(got[base + 6]), 14336);
        chk("tap_out7", longint'(got[base + 7]), 0);
        chk("tap_out8", longint'(got[base + 8]), 0);
        chk("tap_count", longint'(got.size() - base), 10);

        // Saturation both ways
        for (int k = 0; k < int'(NTAPS); k++) wcoef(k, 32767);
        push_n(NTAPS, 32767);
        drain();
        chk("sat_hi", longint'(got[$]), 32767);
        push_n(NTAPS, -32768);
        drain();
        chk("sat_lo", longint'(got[$]), -32768);

        // Backpressure
        m_ready = 1'b0;
        push(16'sd100);
        push(16'sd100);
        for (int i = 0; i < 100 && !m_valid; i++) @(negedge ap_clk);
        v = int'(m_data);
        base = got.size();
        repeat (10) begin
            @(negedge ap_clk);
            chk("bp_stable", longint'(m_data), longint'(v));
            chk("bp_valid", longint'(m_valid), 1);
            chk("bp_s_ready", longint'(s_ready), 0);
            chk("bp_busy", longint'(busy), 1);
        end
        m_ready = 1'b1;
        @(negedge ap_clk);
        chk("bp_release_valid", longint'(m_valid), 0);
        chk("bp_release_ready", longint'(s_ready), 1);
        chk("bp_single", longint'(got.size() - base), 1);

        // Coefficient write gating
        for (int k = 0; k < int'(NTAPS); k++) wcoef(k, 0);
        wcoef(0, 16384);
        push_n(NTAPS, 0);
        drain();
        push(16'sd0);
        push(16'sd100);
        repeat (3) @(negedge ap_clk);
        wcoef(0, 32767);
        drain();
        chk("gate_mac_pass", longint'(got[$]), 50);
        push(16'sd0);
        push(16'sd100);
        drain();
        chk("gate_mac_ignored", longint'(got[$]), 50);
        wcoef(0, 32767);
        push(16'sd0);
        push(16'sd100);
        drain();
        chk("gate_idle_taken", longint'(got[$]), longint'(GATE_EXP));

        // Reset in the middle of a MAC pass
        push(16'sd5);
        push(16'sd7);
        repeat (7) @(negedge ap_clk);
        base = got.size();
        ap_rst = 1'b1;
        #1;
        chk("midrst_busy", longint'(busy), 0);
        chk("midrst_m_valid", longint'(m_valid), 0);
        chk("midrst_s_ready", longint'(s_ready), 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        @(negedge ap_clk);
        chk("midrst_no_emit", longint'(got.size() - base), 0);
        for (int k = 0; k < int'(NTAPS); k++) wcoef(k, 2048 * (k + 1));
        push(16'sd16384);
        push(16'sd0);
        drain();
        chk("postrst_out0", longint'(got[$]), 2048);
        push(16'sd0);
        push(16'sd0);
        drain();
        chk("postrst_out1", longint'(got[$]), 4096);

        // Random traffic, coefficient writes landing in every state
        for (int i = 0; i < 2500; i++) begin
            s_valid   = ($urandom_range(0, 2) != 0);
            s_data    = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) != 0) ? 16'sh7fff : 16'sh8000)
                                                    : 16'($urandom);
            m_ready   = ($urandom_range(0, 3) != 0);
            coef_we   = ($urandom_range(0, 7) == 0);
            coef_addr = AW'($urandom);
            coef_din  = 15'($urandom);
            @(negedge ap_clk);
        end
        s_valid = 1'b0;
        coef_we = 1'b0;
        m_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
